// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared RV32M func3 encodings, muldiv state encoding and special-case constants
package rv32m_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} md_state_e;
endpackage

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide in EX, stalls the pipe while computing
module ex_muldiv_unit
  import rv32m_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_data1,
  input  logic [XLEN-1:0] i_data2,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  md_state_e   r_state, w_next;
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;
  logic [31:0] r_a, r_b, r_result;
  logic [2:0]  r_func3;
  logic        r_neg, r_neg_a;
  logic        w_div, w_sgn1, w_sgn2, w_s1, w_s2, w_zero, w_ovf;
  logic [31:0] w_spec, w_quo, w_rem, w_fix;
  logic [32:0] w_rem_sh, w_rem_sub;
  logic [63:0] w_prod, w_addend;
  assign w_div  = i_func3[2];
  assign w_sgn1 = w_div ? ~i_func3[0] : (i_func3 != F3_MULHU);
  assign w_sgn2 = w_div ? ~i_func3[0] : ~i_func3[1];
  assign w_s1   = w_sgn1 & i_data1[31];
  assign w_s2   = w_sgn2 & i_data2[31];
  assign w_zero = w_div & (i_data2 == 32'd0);
  assign w_ovf  = w_div & ~i_func3[0] & (i_data1 == INT_MIN) & (i_data2 == ALL_ONES);
  assign w_spec = w_zero ? (i_func3[1] ? i_data1 : ALL_ONES) : (i_func3[1] ? 32'd0 : INT_MIN);
  // restoring step: remainder in acc[63:32], quotient shifts into acc[31:0]
  assign w_rem_sh  = {r_acc[63:32], r_a[~r_cnt]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_b};
  assign w_addend  = r_b[r_cnt] ? ({32'd0, r_a} << r_cnt) : 64'd0;
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[31:0] : r_acc[31:0];
  assign w_rem  = r_neg_a ? -r_acc[63:32] : r_acc[63:32];
  assign w_fix  = r_func3[2] ? (r_func3[1] ? w_rem : w_quo)
                             : ((r_func3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32]);
  assign o_stall  = i_rst_n & ~i_flush & (((r_state == IDLE) & i_start) | (r_state == CALC) | (r_state == FIX));
  assign o_done   = (r_state == DONE);
  assign o_result = r_result;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = (w_zero | w_ovf) ? DONE : CALC;
      CALC:    if (r_cnt == 5'd31) w_next = FIX;
      FIX:     w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (i_flush) w_next = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_func3  <= '0;
      r_neg    <= 1'b0;
      r_neg_a  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (!i_flush)
        case (r_state)
          IDLE: if (i_start) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_func3 <= i_func3;
            r_a     <= w_s1 ? -i_data1 : i_data1;
            r_b     <= w_s2 ? -i_data2 : i_data2;
            r_neg   <= w_s1 ^ w_s2;
            r_neg_a <= w_s1;
            if (w_zero | w_ovf) r_result <= w_spec;
          end
          CALC: begin
            r_cnt <= r_cnt + 5'd1;
            if (r_func3[2])
              r_acc <= {w_rem_sub[32] ? w_rem_sh[31:0] : w_rem_sub[31:0], r_acc[30:0], ~w_rem_sub[32]};
            else
              r_acc <= r_acc + w_addend;
          end
          FIX:     r_result <= w_fix;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed vectors with hand-computed results, latencies and stall counts
module tb_ex_muldiv_unit;
  import rv32m_pkg::*;
  logic        i_clk, i_rst_n, i_start, i_flush;
  logic [2:0]  i_func3;
  logic [31:0] i_data1, i_data2;
  logic        o_stall, o_done;
  logic [31:0] o_result;
  int total = 0;
  int bad = 0;
  ex_muldiv_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_flush(i_flush),
    .i_func3(i_func3), .i_data1(i_data1), .i_data2(i_data2),
    .o_stall(o_stall), .o_done(o_done), .o_result(o_result)
  );
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  // called in the low phase; holds Start like ID/EX would until Done is seen
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] exp);
    int n_stall;
    int cyc;
    n_stall = 0;
    cyc = 0;
    i_func3 = f;
    i_data1 = a;
    i_data2 = b;
    i_start = 1'b1;
    #1;
    while (!o_done && cyc < 100) begin
      if (o_stall) n_stall++;
      @(negedge i_clk);
      #1;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_stall_cycles"}, 32'(n_stall), 32'(lat));
    chk({tag, "_stall_in_done"}, {31'd0, o_stall}, 32'd0);
    chk(tag, o_result, exp);
    i_start = 1'b0;
    @(negedge i_clk);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
  endtask
  initial begin
    bit seen_done;
    i_rst_n = 1'b0;
    i_start = 1'b1;
    i_flush = 1'b0;
    i_func3 = F3_MUL;
    i_data1 = 32'd1;
    i_data2 = 32'd1;
    #12;
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    i_start = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_op("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFEB);
    run_op("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000);
    run_op("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF);
    run_op("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD);
    run_op("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF);
    run_op("divu", F3_DIVU, 32'd100, 32'd7, 34, 32'd14);
    run_op("remu", F3_REMU, 32'd100, 32'd7, 34, 32'd2);
    run_op("divu_by0", F3_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("rem_by0", F3_REM, 32'd5, 32'd0, 1, 32'd5);
    run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
    run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    // flush a DIV in cycle 10, then start a MUL in cycle 11
    seen_done = 1'b0;
    i_func3 = F3_DIV;
    i_data1 = 32'd1000;
    i_data2 = 32'd3;
    i_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge i_clk);
      #1;
      if (o_done) seen_done = 1'b1;
    end
    i_flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, o_stall}, 32'd0);
    @(negedge i_clk);
    i_flush = 1'b0;
    i_start = 1'b0;
    #1;
    if (o_done) seen_done = 1'b1;
    chk("flush_no_done", {31'd0, seen_done}, 32'd0);
    chk("flush_result_kept", o_result, 32'h8000_0000);
    run_op("mul_after_flush", F3_MUL, 32'd3, 32'd4, 34, 32'd12);
    // asynchronous reset in cycle 20 of a MUL
    i_func3 = F3_MUL;
    i_data1 = 32'd5;
    i_data2 = 32'd6;
    i_start = 1'b1;
    for (int c = 1; c <= 20; c++) @(negedge i_clk);
    #2;
    chk("pre_rst_stall", {31'd0, o_stall}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, o_stall}, 32'd0);
    chk("mid_rst_done", {31'd0, o_done}, 32'd0);
    chk("mid_rst_result", o_result, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_op("divu_after_rst", F3_DIVU, 32'd9, 32'd3, 34, 32'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the latched operands and func3 of an M-extension instruction. It holds the pipeline through a stall output while it computes. It returns a 32-bit result to the EX/MEM register with a one-cycle Done pulse.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- CLK  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  M-extension instruction present in EX (decoded from ID/EX ALU_Opcode).
- Flush  input  1  synchronous kill of the in-flight operation (branch/jump redirect).
- func3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Data1  input  32  rs1 operand (multiplicand/dividend).
- Data2  input  32  rs2 operand (multiplier/divisor).
- Stall  output  1  holds PC, IF/ID and ID/EX; combinational.
- Done  output  1  registered; Result valid this cycle.
- Result  output  32  registered result, held until the next operation completes.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE with Start=1 and no special case:
  - latch operand magnitudes and sign flags: signed for DIV/REM/MUL/MULH; rs1 only for MULHSU; none for MULHU/DIVU/REMU;
  - clear the 64-bit accumulator and the 5-bit counter;
  - go to CALC.
- CALC, multiply: radix-2 shift-add, one bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC exit: go to FIX after counter reaches 31 (32 iterations).
- FIX:
  - negate the product if the operand signs differ;
  - negate the quotient if the signs differ (and divisor ≠ 0);
  - give the remainder the dividend's sign.
- FIX then loads Result and goes to DONE.
- Result selection:
  - MUL: low 32 bits of the product;
  - MULH/MULHSU/MULHU: high 32 bits;
  - DIV/DIVU: quotient;
  - REM/REMU: remainder.
- Special cases are decided in IDLE, skip CALC/FIX, and go directly to DONE:
  - divisor = 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → Data1;
  - DIV with 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- DONE: Done=1, then IDLE on the next edge.
- Start in DONE is ignored: it is the completing instruction, still held in ID/EX.
- Stall = Reset & ~Flush & ((IDLE & Start) | CALC | FIX). Stall is 0 in DONE so ID/EX advances.
- Flush (any state): next state IDLE, Done not asserted, Result unchanged. Flush has priority over Start.
- Reset low: state IDLE, Result=0, Done=0, accumulator/counter/flags=0, Stall=0, regardless of CLK.

## Timing
- Normal op, Start first seen in IDLE in cycle 0:
  - CALC in cycles 1–32, FIX in cycle 33, DONE in cycle 34;
  - Stall high in cycles 0–33 (34 cycles);
  - Done and Result valid in cycle 34; EX/MEM captures on the edge ending cycle 34.
- Special case: Stall high in cycle 0; Done in cycle 1.
- Back-to-back: the next M instruction reaches EX in cycle 35 and starts at once. There are no bubbles beyond the above.
- Reset released mid-cycle: the first Start is honoured on the first rising edge with Reset high.
- Flush in cycle k of CALC: IDLE in cycle k+1. A Start in cycle k+1 is honoured.

## Structure
- Shared package rv32m_pkg:
  - func3 localparams (MUL…REMU);
  - the state enum encoding (IDLE=0, CALC=1, FIX=2, DONE=3);
  - the special-case constants 0xFFFFFFFF and 0x80000000.
- Single module; no sub-module. The multiply and divide datapaths share the accumulator, operand registers and counter.
- The hazard unit ORs Stall into its existing stall term. The EX result mux selects Result when Done=1.

## Test plan
- MUL Data1=7, Data2=0xFFFFFFFD (−3), Start cycle 0 → Stall high 34 cycles; Done in cycle 34; Result=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. All with Done in cycle 1.
- Flush asserted in cycle 10 of a DIV → no Done pulse; IDLE in cycle 11. A new MUL 3×4 started in cycle 11 → Result=12 in cycle 45.
- Reset low at cycle 20 of a MUL → Stall, Done and Result immediately 0. After release, a DIVU 9/3 → 3 with standard latency.
